// File: rtl/param_stack_if.sv
// param_stack_if
// Bundles the command and status signals of param_stack so producers,
// consumers and the stack itself can share one connection.
//   clear, push, pop, data_in        : commands into the stack
//   data_out, data_valid             : registered popped word and its strobe
//   top, count, full, empty          : live view of the stack contents
//   overflow, underflow              : sticky error flags
// master: the side that issues commands; slave: the stack itself.
interface param_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, pop, data_in,
        input  data_out, data_valid, top, count, full, empty, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, data_in,
        output data_out, data_valid, top, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/param_stack.sv
// param_stack
// Parametrised LIFO stack with simultaneous push/pop (top replacement),
// empty-stack bypass, live top-of-stack peek, occupancy count, sticky
// overflow/underflow flags and a synchronous flush.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : param_stack_if slave modport (commands in, data/status out)
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    param_stack_if.slave      bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             full_w;
    logic             empty_w;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // The index casts truncate count; they are only used when the result
    // is in range (wr_idx when not full, top_idx when not empty).
    assign wr_idx  = AW'(count_q);
    assign top_idx = AW'(count_q - CW'(1));

    // Storage carries no reset: with count at zero its contents are never
    // observed. A replace overwrites the top slot in place.
    always_ff @(posedge clk) begin
        if (!bus.clear) begin
            if (bus.push && !bus.pop && !full_w) begin
                mem[wr_idx] <= bus.data_in;
            end else if (bus.push && bus.pop && !empty_w) begin
                mem[top_idx] <= bus.data_in;
            end
        end
    end

    // Pointer, output register and flags. data_valid defaults low every
    // cycle so it only strobes on a successful pop, replace or bypass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (bus.clear) begin
            count_q      <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (full_w) begin
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty_w) begin
                        underflow_q <= 1'b1;
                    end else begin
                        data_out_q   <= mem[top_idx];
                        data_valid_q <= 1'b1;
                        count_q      <= count_q - CW'(1);
                    end
                end
                2'b11: begin
                    // Empty stack: the pushed word passes straight through.
                    data_out_q   <= empty_w ? bus.data_in : mem[top_idx];
                    data_valid_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.count      = count_q;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.top        = empty_w ? '0 : mem[top_idx];
endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack: the successor to the fixed 8-bit stack, generalised in data width and depth. It adds simultaneous push/pop (top replacement), an empty-stack bypass, a live top-of-stack peek, an occupancy count, sticky overflow/underflow flags and a synchronous flush. It sits beside the original stack in the memory-blocks group and is driven by any single-clock producer/consumer.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2; need not be a power of two)
- CW (localparam), $clog2(DEPTH+1), count width

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted = 0)
- clear  input  1  synchronous flush; highest priority after reset
- push  input  1  push data_in this cycle
- pop  input  1  pop top entry this cycle
- data_in  input  WIDTH  word to push
- data_out  output  WIDTH  registered popped word
- data_valid  output  1  one-cycle strobe: data_out updated this cycle
- top  output  WIDTH  current top-of-stack (combinational from storage); 0 when empty
- count  output  CW  number of stored entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: push attempted while full without pop
- underflow  output  1  sticky: pop attempted while empty without push

## Operation
- Storage: DEPTH×WIDTH register array; stack pointer sp = count; top entry at index sp-1.
- Reset (reset=0, async): count=0, data_out=0, data_valid=0, overflow=0, underflow=0, empty=1, full=0, top=0. Array contents are don't-care.
- Per-cycle priority: reset > clear > push/pop decode.
- clear=1: count←0; data_valid←0; overflow←0; underflow←0; data_out holds; push/pop ignored.
- Decode (clear=0):
  - push only, not full: mem[count]←data_in, count+1.
  - push only, full: dropped, overflow←1, count unchanged.
  - pop only, not empty: data_out←mem[count-1], data_valid←1, count-1.
  - pop only, empty: underflow←1, data_valid←0, data_out holds.
  - push+pop, not empty (including full): replace. data_out←mem[count-1], data_valid←1, mem[count-1]←data_in, count unchanged. Legal, no flag.
  - push+pop, empty: bypass. data_out←data_in, data_valid←1, count stays 0. No flag.
  - neither: data_valid←0, all else holds.
- data_valid is 0 in every cycle with no successful pop, replace or bypass.
- full and empty are decoded from the registered count and are never both 1.
- Flags are sticky until clear or reset. A simultaneous error and clear leaves the flag at 0.

## Timing
- All state updates occur on the rising clk edge. reset acts immediately and releases synchronously to the next edge; there are no operations in the release cycle's edge if reset is still low.
- Push-to-visible latency: 1 cycle. After the edge, top=data_in and count has been incremented.
- Pop latency: 1 cycle. data_out and data_valid are valid after the edge following pop; data_valid is high for exactly that cycle per pop.
- top, full, empty and count reflect post-edge state; top is combinational from count and the array.
- Back-to-back pushes and pops are legal every cycle; throughput is 1 op/cycle.
- Reset mid-operation: all in-flight state is discarded; the first cycle after release sees empty=1.

## Test plan
- WIDTH=8, DEPTH=4. Reset low 2 cycles, then push 0xAA, 0xBB, 0xCC on consecutive cycles -> count 1,2,3; top 0xAA,0xBB,0xCC; empty=0; full=0; data_valid stays 0.
- Pop 3 consecutive cycles -> data_out 0xCC, 0xBB, 0xAA with data_valid=1 on each; count 2,1,0; empty=1 and top=0 after the third pop.
- Push 0x01..0x04 -> full=1. Push 0x05 -> count stays 4, top=0x04, overflow=1. Then push+pop 0x77 -> data_out=0x04, data_valid=1, top=0x77, count=4, overflow still 1.
- Empty stack: pop -> underflow=1, data_valid=0. Then push+pop 0x5A -> data_out=0x5A, data_valid=1, count=0, empty=1. Then clear -> overflow=0, underflow=0.
- Push 0x11, 0x22, then assert reset low asynchronously mid-cycle -> count=0, data_out=0, data_valid=0 immediately. After release, pop -> underflow=1.
- DEPTH=5 (non-power-of-two): 5 pushes -> full=1, count=5. 5 pops return the words in reverse order, then empty=1.
